// File: rtl/core_bus_arbiter_if.sv
// rtl/core_bus_arbiter_if.sv - fetch, data and memory port signals shared by the core bus arbiter
interface core_bus_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              i_valid;
   logic [ADDR_W-1:0] i_addr;
   logic              i_addr_ok;
   logic              i_data_ok;
   logic [DATA_W-1:0] i_rdata;

   logic                d_valid;
   logic [ADDR_W-1:0]   d_addr;
   logic [2:0]          d_size;
   logic [DATA_W/8-1:0] d_strobe;
   logic [DATA_W-1:0]   d_wdata;
   logic                d_addr_ok;
   logic                d_data_ok;
   logic [DATA_W-1:0]   d_rdata;

   logic                m_valid;
   logic [ADDR_W-1:0]   m_addr;
   logic [2:0]          m_size;
   logic [DATA_W/8-1:0] m_strobe;
   logic [DATA_W-1:0]   m_wdata;
   logic                m_addr_ok;
   logic                m_data_ok;
   logic [DATA_W-1:0]   m_rdata;

   // arbiter side
   modport slave (
      input  i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata,
      input  m_addr_ok, m_data_ok, m_rdata,
      output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
      output m_valid, m_addr, m_size, m_strobe, m_wdata
   );

   // requesters and memory side
   modport master (
      output i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata,
      output m_addr_ok, m_data_ok, m_rdata,
      input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
      input  m_valid, m_addr, m_size, m_strobe, m_wdata
   );
endinterface

// File: rtl/core_bus_arbiter.sv
// rtl/core_bus_arbiter.sv - fetch/data arbiter for one memory port, D priority with I starvation guard
module core_bus_arbiter #(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   core_bus_arbiter_if.slave bus,
   output logic              grant_d,
   output logic              busy
);
   localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

   state_t           state;
   logic [CNT_W-1:0] starve_cnt;
   logic             i_starved;

   assign i_starved = bus.i_valid && (starve_cnt == CNT_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         busy       <= 1'b0;
         grant_d    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.d_valid && !i_starved) begin
                  state   <= GRANT_D;
                  busy    <= 1'b1;
                  grant_d <= 1'b1;
                  if (!bus.i_valid)
                     starve_cnt <= '0;
                  else if (starve_cnt != CNT_MAX)
                     starve_cnt <= starve_cnt + CNT_W'(1);
               end else if (bus.i_valid) begin
                  state      <= GRANT_I;
                  busy       <= 1'b1;
                  grant_d    <= 1'b0;
                  starve_cnt <= '0;
               end else begin
                  starve_cnt <= '0;
               end
            end
            GRANT_I, GRANT_D: begin
               // completion is data_ok alone; the IDLE cycle after it is the mandatory bubble
               if (bus.m_data_ok) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  grant_d <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               grant_d <= 1'b0;
            end
         endcase
      end
   end

   // m_valid comes straight from a flop, so m_data_ok never reaches it combinationally
   assign bus.m_valid = busy;

   always_comb begin
      bus.m_addr    = {ADDR_W{1'b0}};
      bus.m_size    = 3'd0;
      bus.m_strobe  = {(DATA_W/8){1'b0}};
      bus.m_wdata   = {DATA_W{1'b0}};
      bus.i_addr_ok = 1'b0;
      bus.i_data_ok = 1'b0;
      bus.i_rdata   = {DATA_W{1'b0}};
      bus.d_addr_ok = 1'b0;
      bus.d_data_ok = 1'b0;
      bus.d_rdata   = {DATA_W{1'b0}};
      case (state)
         GRANT_I: begin
            bus.m_addr    = bus.i_addr;
            bus.m_size    = 3'd3;
            bus.i_addr_ok = bus.m_addr_ok;
            bus.i_data_ok = bus.m_data_ok;
            bus.i_rdata   = bus.m_rdata;
         end
         GRANT_D: begin
            bus.m_addr    = bus.d_addr;
            bus.m_size    = bus.d_size;
            bus.m_strobe  = bus.d_strobe;
            bus.m_wdata   = bus.d_wdata;
            bus.d_addr_ok = bus.m_addr_ok;
            bus.d_data_ok = bus.m_data_ok;
            bus.d_rdata   = bus.m_rdata;
         end
         default: ;
      endcase
   end
endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Shares the single downstream memory port between the core's instruction-fetch requester (I) and data-access requester (D).
- Sits between the core bus interfaces and the memory/cache interconnect.
- Grants one requester at a time and forwards its request unchanged. Routes the response back to the owner only.
- Fixed priority D > I, with a starvation guard that forces an I grant after a bounded wait.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; strobe width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive D grants allowed while I is waiting; the next grant then goes to I.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  fetch request valid.
- i_addr  in  ADDR_W  fetch address.
- i_addr_ok  out  1  fetch request accepted.
- i_data_ok  out  1  fetch data returned.
- i_rdata  out  DATA_W  fetch data.
- d_valid  in  1  data request valid.
- d_addr  in  ADDR_W  data address.
- d_size  in  3  access size (log2 bytes).
- d_strobe  in  DATA_W/8  write byte enables; all-zero means read.
- d_wdata  in  DATA_W  write data.
- d_addr_ok  out  1  data request accepted.
- d_data_ok  out  1  data access done.
- d_rdata  out  DATA_W  read data.
- m_valid  out  1  downstream request valid.
- m_addr  out  ADDR_W  downstream address.
- m_size  out  3  downstream size.
- m_strobe  out  DATA_W/8  downstream byte enables.
- m_wdata  out  DATA_W  downstream write data.
- m_addr_ok  in  1  downstream accepted.
- m_data_ok  in  1  downstream completed.
- m_rdata  in  DATA_W  downstream read data.
- grant_d  out  1  debug: current owner is D.
- busy  out  1  debug: a transaction is in flight.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; starve_cnt=0.
  - All outputs 0: m_valid, m_addr/m_size/m_strobe/m_wdata, all *_ok, all rdata, grant_d, busy.
- States and transitions:
  - IDLE, GRANT_I, GRANT_D.
  - IDLE: arbitrate on the current cycle's valids. The chosen state is registered, so m_valid rises one cycle after the requester's valid (arbitration latency 1).
  - Choice rule:
    - d_valid && !(i_valid && starve_cnt==STARVE_LIMIT) -> GRANT_D.
    - else i_valid -> GRANT_I.
    - else stay IDLE.
  - GRANT_x: m_valid=1; the m_* request fields are driven combinationally from requester x. For GRANT_I: m_size=3, m_strobe=0, m_wdata=0.
  - GRANT_x: x_addr_ok=m_addr_ok, x_data_ok=m_data_ok, x_rdata=m_rdata. The other requester's ok outputs stay 0 and its rdata holds 0.
  - On m_data_ok=1 in GRANT_x: return to IDLE the next cycle. One bubble cycle is mandatory; there is no back-to-back grant.
  - m_addr_ok is forwarded only. Completion is defined by data_ok alone; addr_ok and data_ok may arrive in the same cycle.
- starve_cnt (saturating at STARVE_LIMIT):
  - Increments on each IDLE->GRANT_D transition taken while i_valid=1.
  - Clears on any IDLE->GRANT_I transition.
  - Also clears in IDLE when i_valid=0.
- Requester protocol: once valid is raised, the requester holds valid and all fields stable until its data_ok. A requester dropping valid before data_ok is illegal. The arbiter does not check this and must not hang: it completes on m_data_ok regardless.
- Simultaneous I and D in IDLE: D wins unless starve_cnt==STARVE_LIMIT, in which case I wins.
- busy=1 in GRANT_I/GRANT_D. grant_d=1 in GRANT_D only.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. The downstream is reset by the same reset. No response is delivered for the aborted transaction.
- No combinational path from m_data_ok to m_valid.

Test Plan:
- Single fetch: i_valid=1, i_addr=0x8000_0000; memory returns data_ok after 3 cycles with rdata=0x0000_0013_0000_0093 -> m_valid high from cycle 1; i_data_ok pulses once with that data; d_* outputs stay 0; IDLE bubble follows.
- Write: d_valid=1, d_addr=0x8000_0100, d_strobe=0xFF, d_wdata=0xDEAD_BEEF, d_size=3 -> m_* equals the d_* fields; d_data_ok pulses; i_data_ok=0 throughout.
- Contention: i_valid and d_valid asserted together -> GRANT_D first; after its data_ok plus one bubble, GRANT_I.
- Starvation: i_valid held while d_valid is re-asserted every IDLE cycle -> exactly 4 consecutive D grants, then I is granted; starve_cnt returns to 0.
- Reset abort: assert reset low two cycles into GRANT_D -> outputs 0 asynchronously (same cycle); after release, I-only request completes normally.
- Same-cycle ok: m_addr_ok and m_data_ok both 1 on the first grant cycle -> both forwarded to the owner in that cycle; state is IDLE next cycle.
